// File: rtl/tmds_decoder_if.sv
// Signal bundle for one TMDS receive channel: raw 10-bit words in,
// decoded pixel/control data and alignment status out.
interface tmds_decoder_if;
    logic [9:0] in_raw;
    logic [7:0] out_data;
    logic [1:0] out_c;
    logic       out_blank;
    logic       out_locked;
    logic [3:0] out_offset;

    modport master (
        output in_raw,
        input  out_data, out_c, out_blank, out_locked, out_offset
    );

    modport slave (
        input  in_raw,
        output out_data, out_c, out_blank, out_locked, out_offset
    );
endinterface

// File: rtl/tmds_decoder.sv
// One-channel TMDS receiver: finds the 10-bit word boundary by bit-slipping
// until a run of control tokens is seen, then decodes data and control words.
module tmds_decoder #(
    parameter int c_lock_tokens    = 16,
    parameter int c_search_timeout = 4096
) (
    input  logic           clk_pixel,
    input  logic           rst_n,
    tmds_decoder_if.slave  tmds
);
    localparam int RUN_W = $clog2(c_lock_tokens + 1);
    localparam int TMO_W = $clog2(c_search_timeout);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(c_lock_tokens);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(c_search_timeout - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [3:0]       offset, offset_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             slip;

    logic [9:0]  prev_raw_p0;
    logic [19:0] cat, shifted;
    logic [9:0]  word;
    logic        is_tok;
    logic [1:0]  tok_c;

    logic [7:0]  data_p1;
    logic [1:0]  c_p1;
    logic        blank_p1;

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_FULL) ? v : v + 1'b1;
    endfunction

    // Stage p0: hold the previous raw word so any 10-bit window of the stream is reachable
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) prev_raw_p0 <= '0;
        else        prev_raw_p0 <= tmds.in_raw;
    end

    assign cat     = {tmds.in_raw, prev_raw_p0};
    assign shifted = cat >> offset;
    assign word    = shifted[9:0];

    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (word)
            10'h354: tok_c = 2'b00;
            10'h0AB: tok_c = 2'b01;
            10'h154: tok_c = 2'b10;
            10'h2AB: tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        run_nxt    = is_tok ? sat_inc(run_cnt) : '0;
        tmo_nxt    = (run_cnt == RUN_FULL) ? '0 : tmo_cnt + 1'b1;
        slip       = 1'b0;
        case (state)
            SEARCH: begin
                // A completed run takes priority over a coincident timeout
                if (run_cnt == RUN_FULL)   state_nxt = LOCKED;
                else if (tmo_cnt == TMO_LAST) slip   = 1'b1;
            end
            LOCKED: begin
                if (run_cnt != RUN_FULL && tmo_cnt == TMO_LAST) begin
                    state_nxt = SEARCH;
                    slip      = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (slip) begin
            offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            run_nxt    = '0;
            tmo_nxt    = '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            offset  <= 4'd0;
            run_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            offset  <= offset_nxt;
            run_cnt <= run_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Stage p1: decoded outputs, gated by the lock state that takes effect at this edge
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            data_p1  <= 8'h00;
            c_p1     <= 2'b00;
            blank_p1 <= 1'b1;
        end else if (state_nxt != LOCKED) begin
            data_p1  <= 8'h00;
            c_p1     <= 2'b00;
            blank_p1 <= 1'b1;
        end else if (is_tok) begin
            c_p1     <= tok_c;
            blank_p1 <= 1'b1;
        end else begin
            data_p1  <= tmds_decode(word);
            blank_p1 <= 1'b0;
        end
    end

    assign tmds.out_data   = data_p1;
    assign tmds.out_c      = c_p1;
    assign tmds.out_blank  = blank_p1;
    assign tmds.out_locked = (state == LOCKED);
    assign tmds.out_offset = offset;
endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: lock/slip timing, data/control decode through a
// scoreboard, forced loss of lock, offset wrap and asynchronous reset.
module tb_tmds_decoder;
    logic clk_pixel = 1'b0;
    logic rst_n     = 1'b0;
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_bad     = 0;

    tmds_decoder_if bus();

    tmds_decoder dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .tmds      (bus)
    );

    always #5 clk_pixel = ~clk_pixel;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] w;
        logic [7:0] data;
        logic [1:0] c;
        logic       blank;
    } vec_t;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] data;
        logic [1:0] c;
        logic       blank;
    } exp_t;

    exp_t sbq[$];
    vec_t tab[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] rotl10(input logic [9:0] v, input int k);
        logic [19:0] t;
        t = {v, v} << k;
        return t[19:10];
    endfunction

    // Scoreboard: each word's expected outputs come due two edges after it is driven
    always @(negedge clk_pixel) begin : sb_check
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check($sformatf("vec%0d out_data", e.idx), bus.out_data, e.data);
            check($sformatf("vec%0d out_c", e.idx), bus.out_c, e.c);
            check($sformatf("vec%0d out_blank", e.idx), bus.out_blank, e.blank);
        end
    end

    task automatic do_reset(input logic [9:0] w);
        @(negedge clk_pixel);
        rst_n      = 1'b0;
        bus.in_raw = w;
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
    endtask

    task automatic wait_lock(input logic want, input int limit, output int n);
        n = 0;
        while (bus.out_locked !== want && n < limit) begin
            @(negedge clk_pixel);
            n++;
        end
    endtask

    initial begin
        int n;
        int prev_off;
        int steps;

        tab = '{
            '{10'h100, 8'h00, 2'b01, 1'b0},
            '{10'h2FF, 8'hFE, 2'b01, 1'b0},
            '{10'h200, 8'hFF, 2'b01, 1'b0},
            '{10'h2AB, 8'hFF, 2'b11, 1'b1},
            '{10'h1FF, 8'h01, 2'b11, 1'b0},
            '{10'h0FF, 8'hFF, 2'b11, 1'b0},
            '{10'h354, 8'hFF, 2'b00, 1'b1},
            '{10'h155, 8'hFF, 2'b00, 1'b0},
            '{10'h000, 8'hFE, 2'b00, 1'b0},
            '{10'h154, 8'hFE, 2'b10, 1'b1},
            '{10'h1F0, 8'h10, 2'b10, 1'b0},
            '{10'h00F, 8'hEF, 2'b10, 1'b0},
            '{10'h3AA, 8'hFF, 2'b10, 1'b0},
            '{10'h0AB, 8'hFF, 2'b01, 1'b1}
        };

        // Reset state with an aligned 0x0AB stream waiting
        bus.in_raw = 10'h0AB;
        repeat (3) @(negedge clk_pixel);
        check("rst out_locked", bus.out_locked, 0);
        check("rst out_offset", bus.out_offset, 0);
        check("rst out_blank", bus.out_blank, 1);
        check("rst out_data", bus.out_data, 0);
        check("rst out_c", bus.out_c, 0);
        rst_n = 1'b1;

        // Aligned lock: 16 tokens plus two cycles of pipeline
        repeat (17) @(negedge clk_pixel);
        check("t1 locked early", bus.out_locked, 0);
        @(negedge clk_pixel);
        check("t1 out_locked", bus.out_locked, 1);
        check("t1 out_c", bus.out_c, 2'b01);
        check("t1 out_blank", bus.out_blank, 1);
        check("t1 out_offset", bus.out_offset, 0);

        // Locked decode vectors through the scoreboard
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_pixel);
            bus.in_raw = tab[i].w;
            sbq.push_back('{cyc + 2, i, tab[i].data, tab[i].c, tab[i].blank});
        end
        repeat (3) @(negedge clk_pixel);

        // Data-only stream drops lock and slips the offset
        bus.in_raw = 10'h100;
        wait_lock(1'b0, 4200, n);
        check("t4 lock held during data", (n > 4000), 1);
        check("t4 out_locked", bus.out_locked, 0);
        check("t4 out_offset", bus.out_offset, 1);
        check("t4 out_blank", bus.out_blank, 1);
        check("t4 out_data", bus.out_data, 0);
        check("t4 out_c", bus.out_c, 0);

        // Stream rotated by 3: slips every 4096 cycles, lock at offset 3
        do_reset(rotl10(10'h0AB, 3));
        repeat (4095) @(negedge clk_pixel);
        check("t2 offset before slip", bus.out_offset, 0);
        @(negedge clk_pixel);
        check("t2 offset after slip", bus.out_offset, 1);
        wait_lock(1'b1, 2 * 4096 + 100, n);
        check("t2 lock cycle", n, 8209);
        check("t2 out_locked", bus.out_locked, 1);
        check("t2 out_offset", bus.out_offset, 3);
        check("t2 out_c", bus.out_c, 2'b01);
        check("t2 out_blank", bus.out_blank, 1);

        // Lose lock to offset 4, then relock on a rotate-by-5 stream at offset 5
        bus.in_raw = 10'h100;
        wait_lock(1'b0, 4200, n);
        check("t4b out_offset", bus.out_offset, 4);
        bus.in_raw = rotl10(10'h0AB, 5);
        wait_lock(1'b1, 4300, n);
        check("t6 pre out_locked", bus.out_locked, 1);
        check("t6 pre out_offset", bus.out_offset, 5);

        // Asynchronous reset pulse mid-cycle while locked
        repeat (10) @(negedge clk_pixel);
        @(posedge clk_pixel);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async out_locked", bus.out_locked, 0);
        check("t6 async out_offset", bus.out_offset, 0);
        check("t6 async out_blank", bus.out_blank, 1);
        check("t6 async out_data", bus.out_data, 0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        bus.in_raw = rotl10(10'h0AB, 3);
        rst_n      = 1'b1;
        wait_lock(1'b1, 3 * 4096 + 100, n);
        check("t6 relock cycle", n, 12305);
        check("t6 relock offset", bus.out_offset, 3);

        // Rotation of 9: offsets step 0..9, then lock loss wraps to 0
        do_reset(rotl10(10'h0AB, 9));
        prev_off = 0;
        steps    = 0;
        n        = 0;
        while (bus.out_locked !== 1'b1 && n < 10 * 4096 + 100) begin
            @(negedge clk_pixel);
            n++;
            if (bus.out_offset != prev_off[3:0]) begin
                check("t5 offset step", bus.out_offset, prev_off + 1);
                prev_off = int'(bus.out_offset);
                steps++;
            end
        end
        check("t5 slip count", steps, 9);
        check("t5 out_locked", bus.out_locked, 1);
        check("t5 out_offset", bus.out_offset, 9);
        bus.in_raw = 10'h100;
        wait_lock(1'b0, 4200, n);
        check("t5 wrap out_locked", bus.out_locked, 0);
        check("t5 wrap out_offset", bus.out_offset, 0);
        check("t5 wrap out_blank", bus.out_blank, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
